// File: rtl/serial_byte_tx.sv
// serial_byte_tx: LSB-first bit-serial transmitter framed by a start bit (0) and a stop bit (1).
// Defining SERIAL_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high, TxReady high, waiting for TxStart
// START  | start bit (0) for one bit period
// DATA   | data bits, LSB first, one bit period each
// PARITY | even-parity bit (only with SERIAL_TX_PARITY_EN)
// STOP   | stop bit (1); TxDone pulses in its final cycle
module serial_byte_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             TxData,
  input  logic                          TxStart,
  output logic                          TxReady,
  output logic                          TxOut,
  output logic                          TxDone,
  output logic [$clog2(DATA_W+1)-1:0]   BitCount
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DONE_TICK = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic          ONE_TICK  = (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [CW-1:0]     tick;
  logic [DATA_W-1:0] shiftReg;
  logic [DATA_W-1:0] shifted;
`ifdef SERIAL_TX_PARITY_EN
  logic              parityBit;
`endif

  assign shifted = shiftReg >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick     <= '0;
      shiftReg <= '0;
      BitCount <= '0;
      TxOut    <= 1'b1;
      TxReady  <= 1'b1;
      TxDone   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (TxStart) begin
            shiftReg <= TxData;
            BitCount <= '0;
            tick     <= '0;
            TxOut    <= 1'b0;
            TxReady  <= 1'b0;
            state    <= START;
`ifdef SERIAL_TX_PARITY_EN
            parityBit <= ^TxData;
`endif
          end
        end
        START: begin
          if (tick == LAST_TICK) begin
            tick  <= '0;
            TxOut <= shiftReg[0];
            state <= DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == LAST_TICK) begin
            tick     <= '0;
            shiftReg <= shifted;
            BitCount <= BitCount + 1'b1;
            if (BitCount == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
              TxOut <= parityBit;
              state <= PARITY;
`else
              TxOut  <= 1'b1;
              TxDone <= ONE_TICK;
              state  <= STOP;
`endif
            end else begin
              TxOut <= shifted[0];
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        PARITY: begin
          if (tick == LAST_TICK) begin
            tick   <= '0;
            TxOut  <= 1'b1;
            TxDone <= ONE_TICK;
            state  <= STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        STOP: begin
          // TxDone is registered, so it is raised one tick ahead of the last stop cycle
          if (tick == LAST_TICK) begin
            tick    <= '0;
            TxDone  <= 1'b0;
            TxReady <= 1'b1;
            state   <= IDLE;
          end else begin
            tick   <= tick + 1'b1;
            TxDone <= (tick == DONE_TICK);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_tx.sv
// Bench for serial_byte_tx: two lanes (CLKS_PER_BIT 4 and 1), frame-level reference model,
// and a line receiver whose decoded frames are scoreboarded against accepted requests.
`timescale 1ns/1ps
module tb_serial_byte_tx;
  localparam int DW = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    int            acc;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [2];
  logic          start [2];
  logic [DW-1:0] din   [2];

  int nChecks = 0;
  int nFails  = 0;
  int nFrames = 0;

  task automatic chk(string nm, int ln, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s lane%0d @%0t: got %0h, expected %0h", nm, ln, $time, act, exp);
    end
  endtask

  // Expected line level during bit slot b of a frame carrying d
  function automatic logic frameBit(logic [DW-1:0] d, int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
    if (PAR == 1 && b == DW + 1) return ^d;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int P = (g == 0) ? 4 : 1;
    localparam int F = (DW + 2 + PAR) * P;

    logic          txReady, txOut, txDone;
    logic [3:0]    bitCount;
    frame_t        q[$];
    int            edgeN  = 0;
    int            curAcc = -1;
    int            bcHold = 0;
    int            resets = 0;
    logic [DW-1:0] curData = '0;
    bit            armed = 1'b0;

    serial_byte_tx #(.DATA_W(DW), .CLKS_PER_BIT(P)) dut (
      .clk(clk), .reset(rst[g]), .TxData(din[g]), .TxStart(start[g]),
      .TxReady(txReady), .TxOut(txOut), .TxDone(txDone), .BitCount(bitCount));

    // Reference model: one frame of F cycles per accepted request, busy through edge acc+F
    initial forever begin
      @(posedge clk);
      edgeN++;
      if (rst[g] === 1'b1) begin
        curAcc = -1;
        bcHold = 0;
        q.delete();
        resets++;
        armed = 1'b1;
      end else if (curAcc >= 0) begin
        if (edgeN - curAcc >= F) begin
          curAcc = -1;
          bcHold = DW;
        end
      end else if (start[g] === 1'b1) begin
        curAcc  = edgeN;
        curData = din[g];
        q.push_back('{din[g], edgeN});
      end
    end

    initial begin
      int            seenResets, s, d, b, expBc;
      bit            rxActive;
      logic [DW-1:0] rxData;
      logic          rxPar, rxStop, expOut, expRdy, expDone;
      frame_t        f;
      seenResets = 0; s = 0; rxActive = 1'b0; rxData = '0; rxPar = 1'b0; rxStop = 1'b0;
      forever begin
        @(negedge clk);
        if (armed) begin
          if (curAcc >= 0) begin
            d       = edgeN - curAcc;
            expOut  = frameBit(curData, d / P);
            expRdy  = 1'b0;
            expDone = (d == F - 1);
            expBc   = d / P - 1;
            if (expBc < 0) expBc = 0;
            if (expBc > DW) expBc = DW;
          end else begin
            expOut = 1'b1; expRdy = 1'b1; expDone = 1'b0; expBc = bcHold;
          end
          chk("TxOut", g, 32'(txOut), 32'(expOut));
          chk("TxReady", g, 32'(txReady), 32'(expRdy));
          chk("TxDone", g, 32'(txDone), 32'(expDone));
          chk("BitCount", g, 32'(bitCount), 32'(expBc));

          // Line receiver: samples mid-bit from the start-bit falling edge
          if (resets != seenResets) begin
            seenResets = resets;
            rxActive = 1'b0;
          end
          if (rxActive) s++;
          else if (txOut === 1'b0) begin
            rxActive = 1'b1;
            s = 0;
          end
          if (rxActive && (s % P == P / 2)) begin
            b = s / P;
            if (b >= 1 && b <= DW) rxData[b-1] = txOut;
            else if (PAR == 1 && b == DW + 1) rxPar = txOut;
            else if (b == DW + 1 + PAR) rxStop = txOut;
          end
          if (txDone === 1'b1) begin
            if (q.size() == 0) begin
              chk("unexpectedDone", g, 32'd1, 32'd0);
            end else begin
              f = q.pop_front();
              nFrames++;
              chk("frameData", g, 32'(rxData), 32'(f.data));
              chk("doneEdge", g, 32'(edgeN), 32'(f.acc + F - 1));
              chk("frameLen", g, 32'(s), 32'(F - 1));
              chk("stopBit", g, 32'(rxStop), 32'd1);
              if (PAR == 1) chk("parityBit", g, 32'(rxPar), 32'(^f.data));
            end
          end
          if (rxActive && s >= F - 1) rxActive = 1'b0;
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int g, logic [DW-1:0] d);
    din[g] = d;
    start[g] = 1'b1;
    cyc(1);
    start[g] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; din[g] = '0;
    end
    cyc(3);
    rst[0] = 1'b0; rst[1] = 1'b0;
    cyc(3);

    send(0, 8'hA5);
    cyc(50);

    // TxStart held through two frames; data changes only after the first accept
    din[0] = 8'h00; start[0] = 1'b1;
    cyc(5);
    din[0] = 8'hFF;
    cyc(45);
    start[0] = 1'b0;
    cyc(50);

    // Intruding request at cycle 12 must be ignored
    send(0, 8'h81);
    cyc(11);
    din[0] = 8'h3C; start[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
    cyc(45);

    // Reset mid-frame, then a fresh frame
    send(0, 8'hC3);
    cyc(19);
    rst[0] = 1'b1;
    cyc(1);
    rst[0] = 1'b0;
    cyc(2);
    send(0, 8'h5A);
    cyc(50);

    // Reset and start on the same edge: nothing accepted
    rst[0] = 1'b1; din[0] = 8'hEE; start[0] = 1'b1;
    cyc(1);
    rst[0] = 1'b0; start[0] = 1'b0;
    cyc(5);

    send(0, 8'h07);
    cyc(50);
    send(0, 8'h03);
    cyc(50);

    send(1, 8'h55);
    cyc(15);

    repeat (1500) begin
      for (int g = 0; g < 2; g++) begin
        rst[g]   = ($urandom_range(0, 199) == 0);
        start[g] = ($urandom_range(0, 7) == 0);
        din[g]   = DW'($urandom);
      end
      cyc(1);
    end
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b0; start[g] = 1'b0;
    end
    cyc(60);

    chk("drain", 0, 32'(lane[0].q.size()), 32'd0);
    chk("drain", 1, 32'(lane[1].q.size()), 32'd0);
    chk("enoughFrames", 0, 32'(nFrames >= 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/serial_byte_tx.md
# serial_byte_tx

Bit-serial byte transmitter: accepts a parallel byte on a ready/start handshake and shifts it out LSB-first on a single line, framed by a start bit (0) and a stop bit (1). It is the sending end of the serial link whose receive side uses the 8-bit bit counter. It exposes its own running bit count so benches can cross-check it against the receiver's count.

## Interface
- `DATA_W`, default 8, number of data bits per frame (1–16).
- `CLKS_PER_BIT`, default 4, clock cycles per serial bit (≥1).
- `clk`  input  1  rising-edge clock; the block's only clock.
- `reset`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `TxData`  input  DATA_W  byte to send; sampled only on an accepted start.
- `TxStart`  input  1  request to send; accepted on an edge where `TxReady`=1.
- `TxReady`  output  1  high while idle and able to accept.
- `TxOut`  output  1  serial line; idles high.
- `TxDone`  output  1  one-cycle pulse during the final cycle of the stop bit.
- `BitCount`  output  ⌈log2(DATA_W+1)⌉ (4 at default)  data bits fully sent in the current or last frame.

## Operation
- States: IDLE, START, DATA, (PARITY), STOP. Registers: a shift register of DATA_W bits, a bit-period counter from 0 to CLKS_PER_BIT-1, and `BitCount`.
- IDLE: `TxOut`=1, `TxReady`=1. When `TxStart`=1 on an edge:
  - latch `TxData`;
  - clear `BitCount` and the period counter;
  - go to START.
- START: `TxOut`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `TxOut` = shift register bit 0, so the LSB is sent first.
  - At the end of each bit period, shift right and increment `BitCount`.
  - After DATA_W bits, go to PARITY if it is compiled in, otherwise to STOP.
- PARITY: `TxOut` = XOR of all latched data bits (even parity), for one bit period.
- STOP: `TxOut`=1 for CLKS_PER_BIT cycles. `TxDone`=1 during the last cycle only. Then go to IDLE.
- `TxStart` outside IDLE is ignored; it is not queued. A change on `TxData` mid-frame has no effect.
- Reset values, from the edge with `reset`=1 onward: state IDLE, `TxOut`=1, `TxReady`=1, `TxDone`=0, `BitCount`=0, shift register 0.
- Reset mid-frame aborts the frame immediately. No `TxDone` is produced.
- `reset` and `TxStart` on the same edge: reset wins and nothing is accepted.
- `BitCount` saturates at DATA_W and holds that value through PARITY, STOP and IDLE until the next accept.

## Timing
- All outputs are registered. Let accept edge = k and P = CLKS_PER_BIT.
- Start bit occupies edges k..k+P (`TxOut`=0 from after edge k).
- Data bit i is on the line from edge k+(i+1)·P to edge k+(i+2)·P.
- `BitCount` becomes i+1 at edge k+(i+2)·P.
- Frame length F = (DATA_W+2)·P cycles, or (DATA_W+3)·P with parity. Default: 40, or 44 with parity.
- `TxDone` is high from edge k+F-1 to edge k+F. `TxReady` rises at edge k+F.
- Earliest next accept is edge k+F+1. This gives at least one idle cycle, with the line high, between frames.
- `TxReady` falls at edge k.
- CLKS_PER_BIT=1 is legal: every state lasts exactly one cycle.

## Configuration
- `SERIAL_TX_PARITY_EN`:
  - Defined: the PARITY state is inserted between DATA and STOP, sending an even-parity bit, and frames are one bit longer.
  - Undefined: DATA goes directly to STOP. No parity logic is synthesized.

## Test plan
- Send 0xA5 with default parameters: line shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit lasting 4 cycles. `TxDone` pulses at cycle 39 after accept, `BitCount`=8 at the end, `TxReady` high at cycle 40.
- Hold `TxStart`=1 continuously with data 0x00, then 0xFF: the second frame's start bit begins exactly one idle cycle after the first `TxReady` rise, and both frames are correct.
- Pulse `TxStart` with 0x3C at cycle 12 of a 0x81 frame: the 0x81 frame is unaffected and no second frame is sent.
- Assert `reset` at cycle 20 of a frame: from the next edge `TxOut`=1, `TxReady`=1 and `BitCount`=0, with no `TxDone`. A new accept afterwards produces a correct frame.
- With `SERIAL_TX_PARITY_EN` defined, send 0x07 then 0x03: parity bit is 1, then 0. `TxDone` is at cycle 43 and the frame is 44 cycles.
- With CLKS_PER_BIT=1 and DATA_W=8, send 0x55: a 10-cycle frame alternating 0,1,0,1,… and ending in 1, with `TxDone` at cycle 9.
